// File: rtl/ebus_responder.sv
// EBUS device responder: decodes controller-select, runs CONO/DATAO write strobes
// and CONI/DATAI read drives with a bounded devReady wait and sticky timeout flag.
package ebus_pkg;
   typedef struct packed {
      logic        driving;
      logic [0:35] data;
   } tEBUSdriver;
endpackage

module ebus_responder
   import ebus_pkg::*;
#(
   parameter logic [6:0] DEV_CODE   = 7'o000,
   parameter int         WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        CROBAR_N,
   input  logic [6:0]  ebusCS,
   input  logic [2:0]  ebusFunc,
   input  logic        ebusDemand,
   input  logic [0:35] ebusData,
   output logic        ebusXfer,
   output tEBUSdriver  EBUSdriver,
   output logic        conoStrobe,
   output logic        dataoStrobe,
   output logic [0:35] wrData,
   input  logic [0:35] coniValue,
   input  logic [0:35] dataiValue,
   input  logic        devReady,
   output logic        timedOut,
   input  logic        timeoutClr
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_RDWAIT, S_RDDRIVE, S_XFER, S_RELEASE
   } state_e;

   localparam logic [2:0] F_CONI  = 3'd0;
   localparam logic [2:0] F_CONO  = 3'd1;
   localparam logic [2:0] F_DATAI = 3'd2;
   localparam logic [2:0] F_DATAO = 3'd3;

   state_e        state_q, state_d;
   logic          datao_q, datao_d;   // write kind: 1 = DATAO, 0 = CONO
   logic          rd_q, rd_d;         // read transaction keeps driving through XFER
   logic [0:35]   data_q, data_d;
   logic [0:35]   wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;
   logic          to_set;
   logic          select;

   assign select = ebusDemand && (ebusCS == DEV_CODE) && (ebusFunc <= F_DATAO);

   always_ff @(posedge clk or negedge CROBAR_N) begin
      if (!CROBAR_N) begin
         state_q <= S_IDLE;
         datao_q <= 1'b0;
         rd_q    <= 1'b0;
         data_q  <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         datao_q <= datao_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      datao_d = datao_q;
      rd_d    = rd_q;
      data_d  = data_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      to_set  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (select) begin
               case (ebusFunc)
                  F_CONI: begin
                     data_d  = coniValue;
                     rd_d    = 1'b1;
                     state_d = S_RDDRIVE;
                  end
                  F_DATAI: begin
                     rd_d    = 1'b1;
                     cnt_d   = '0;
                     state_d = S_RDWAIT;
                  end
                  default: begin
                     wr_d    = ebusData;
                     datao_d = (ebusFunc == F_DATAO);
                     rd_d    = 1'b0;
                     state_d = S_WRITE;
                  end
               endcase
            end
         end
         S_WRITE:   state_d = S_XFER;
         S_RDWAIT: begin
            // counter tops out at WAIT_LIMIT, the state is left on that same edge
            cnt_d = cnt_q + CW'(1);
            if (devReady) begin
               data_d  = dataiValue;
               state_d = S_RDDRIVE;
            end else if (cnt_q == CW'(WAIT_LIMIT - 1)) begin
               data_d  = '0;
               to_set  = 1'b1;
               state_d = S_RDDRIVE;
            end
         end
         S_RDDRIVE: state_d = S_XFER;
         S_XFER: begin
            if (!ebusDemand) state_d = S_RELEASE;
         end
         S_RELEASE: begin
            data_d  = '0;
            rd_d    = 1'b0;
            state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
      to_d = to_set ? 1'b1 : (timeoutClr ? 1'b0 : to_q);
   end

   always_comb begin
      conoStrobe         = 1'b0;
      dataoStrobe        = 1'b0;
      ebusXfer           = 1'b0;
      EBUSdriver.driving = 1'b0;
      case (state_q)
         S_WRITE: begin
            conoStrobe  = !datao_q;
            dataoStrobe = datao_q;
         end
         S_RDDRIVE: EBUSdriver.driving = 1'b1;
         S_XFER: begin
            ebusXfer           = 1'b1;
            EBUSdriver.driving = rd_q;
         end
         default: ;
      endcase
      EBUSdriver.data = EBUSdriver.driving ? data_q : '0;
   end

   assign wrData   = wr_q;
   assign timedOut = to_q;

endmodule

// File: tb/tb_ebus_responder.sv
// Directed plus randomized bench for ebus_responder, checked against a
// timeline model derived from the transaction latency and handshake rules.
module tb_ebus_responder;
   import ebus_pkg::*;

   localparam logic [6:0] DEV = 7'o020;
   localparam int         WL  = 16;

   logic        clk;
   logic        CROBAR_N;
   logic [6:0]  ebusCS;
   logic [2:0]  ebusFunc;
   logic        ebusDemand;
   logic [0:35] ebusData;
   logic        ebusXfer;
   tEBUSdriver  drv;
   logic        conoStrobe, dataoStrobe;
   logic [0:35] wrData;
   logic [0:35] coniValue, dataiValue;
   logic        devReady;
   logic        timedOut;
   logic        timeoutClr;

   int n_assert = 0;
   int n_fail   = 0;
   bit exp_to   = 1'b0;

   ebus_responder #(.DEV_CODE(DEV), .WAIT_LIMIT(WL)) dut (
      .clk(clk), .CROBAR_N(CROBAR_N), .ebusCS(ebusCS), .ebusFunc(ebusFunc),
      .ebusDemand(ebusDemand), .ebusData(ebusData), .ebusXfer(ebusXfer),
      .EBUSdriver(drv), .conoStrobe(conoStrobe), .dataoStrobe(dataoStrobe),
      .wrData(wrData), .coniValue(coniValue), .dataiValue(dataiValue),
      .devReady(devReady), .timedOut(timedOut), .timeoutClr(timeoutClr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [35:0] rnd36();
      return {4'($urandom), 32'($urandom)};
   endfunction

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0o required %0o", tag, obs, exp);
      end
   endtask

   task automatic quiet(input string tag);
      chk({tag, " xfer"}, 36'(ebusXfer), 36'(0));
      chk({tag, " drv"}, 36'(drv.driving), 36'(0));
      chk({tag, " data"}, 36'(drv.data), 36'(0));
      chk({tag, " strb"}, 36'({conoStrobe, dataoStrobe}), 36'(0));
   endtask

   // One transaction starting with the select edge as edge 1; cycle c is the
   // interval after edge c. Expected waveform comes from the latency rules.
   task automatic run(input string name, input logic [6:0] cs, input logic [2:0] func,
                      input logic [35:0] data, input logic [35:0] cv, input logic [35:0] dv,
                      input int w, input int hold, input bit rclr);
      bit sel, rd, to, clr, xf, dr;
      int x, d, e, last;
      logic [35:0] rv;
      sel  = (cs == DEV) && (func <= 3'd3);
      rd   = sel && (func == 3'd0 || func == 3'd2);
      to   = sel && func == 3'd2 && w >= WL;
      x    = (sel && func == 3'd2) ? (to ? WL + 2 : w + 3) : 2;
      d    = sel ? ((x + hold < 1) ? 1 : x + hold) : 4;
      e    = (x > d) ? x : d;
      last = sel ? e + 2 : 6;
      rv   = (func == 3'd0) ? cv : (to ? 36'(0) : dv);
      ebusCS = cs; ebusFunc = func; ebusData = data; coniValue = cv; dataiValue = dv;
      ebusDemand = 1'b1; devReady = 1'b0; timeoutClr = 1'b0; clr = 1'b0;
      for (int c = 1; c <= last; c++) begin
         @(posedge clk);
         if (to && c == x - 1) exp_to = 1'b1;
         else if (clr) exp_to = 1'b0;
         #1;
         ebusDemand = (c < d);
         devReady   = (c >= w + 1);
         clr        = (to && c == x - 2) || (rclr && $urandom_range(0, 5) == 0);
         timeoutClr = clr;
         if (sel) begin
            ebusData = rnd36();
            ebusFunc = 3'($urandom);
            ebusCS   = 7'($urandom);
            if (func == 3'd0) coniValue = rnd36();
            if (func == 3'd2 && c >= x - 1) dataiValue = rnd36();
         end
         @(negedge clk);
         xf = sel && c >= x && c <= e;
         dr = rd && c >= x - 1 && c <= e;
         chk($sformatf("%s c%0d xfer", name, c), 36'(ebusXfer), 36'(xf));
         chk($sformatf("%s c%0d drv", name, c), 36'(drv.driving), 36'(dr));
         chk($sformatf("%s c%0d data", name, c), 36'(drv.data), dr ? rv : 36'(0));
         chk($sformatf("%s c%0d cono", name, c), 36'(conoStrobe), 36'(sel && func == 3'd1 && c == 1));
         chk($sformatf("%s c%0d datao", name, c), 36'(dataoStrobe), 36'(sel && func == 3'd3 && c == 1));
         if (sel && (func == 3'd1 || func == 3'd3) && c == 1)
            chk($sformatf("%s wrData", name), 36'(wrData), data);
         chk($sformatf("%s c%0d timedOut", name, c), 36'(timedOut), 36'(exp_to));
      end
   endtask

   initial begin
      CROBAR_N = 1'b0; ebusCS = '0; ebusFunc = '0; ebusDemand = 1'b0; ebusData = '0;
      coniValue = '0; dataiValue = '0; devReady = 1'b0; timeoutClr = 1'b0;
      #3;
      quiet("reset");
      chk("reset wrData", 36'(wrData), 36'(0));
      chk("reset timedOut", 36'(timedOut), 36'(0));
      @(posedge clk); #1 CROBAR_N = 1'b1;
      @(negedge clk);

      run("cono", DEV, 3'd1, 36'o123456701234, 36'o0, 36'o0, 0, 1, 1'b0);
      run("coni", DEV, 3'd0, 36'o0, 36'o777000000777, 36'o0, 0, 2, 1'b0);
      run("datai5", DEV, 3'd2, 36'o0, 36'o0, 36'o1, 5, 1, 1'b0);
      run("datai0", DEV, 3'd2, 36'o0, 36'o0, 36'o707070707070, 0, 0, 1'b0);
      run("datai15", DEV, 3'd2, 36'o0, 36'o0, 36'o555, WL - 1, 1, 1'b0);
      run("timeout", DEV, 3'd2, 36'o0, 36'o0, 36'o777777777777, 100, 2, 1'b0);
      timeoutClr = 1'b1;
      @(posedge clk); exp_to = 1'b0;
      #1 timeoutClr = 1'b0;
      @(negedge clk);
      chk("timeoutClr", 36'(timedOut), 36'(exp_to));
      run("badcs", 7'o024, 3'd1, 36'o1, 36'o2, 36'o3, 0, 0, 1'b0);
      run("func5", DEV, 3'd5, 36'o1, 36'o2, 36'o3, 0, 0, 1'b0);
      run("datao", DEV, 3'd3, 36'o400000000001, 36'o0, 36'o0, 0, 3, 1'b0);
      run("abortw", DEV, 3'd1, 36'o246, 36'o0, 36'o0, 0, -1, 1'b0);
      run("abortr", DEV, 3'd2, 36'o0, 36'o0, 36'o135, 3, -4, 1'b0);

      for (int i = 0; i < 24; i++) begin
         logic [6:0] cs;
         logic [2:0] fn;
         cs = ($urandom_range(0, 4) == 0) ? 7'($urandom) : DEV;
         fn = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         run($sformatf("rnd%0d", i), cs, fn, rnd36(), rnd36(), rnd36(),
             int'($urandom_range(0, 20)), int'($urandom_range(0, 4)) - 1, 1'b1);
      end

      // reset while a DATAI read sits in XFER
      ebusCS = DEV; ebusFunc = 3'd2; ebusDemand = 1'b1; devReady = 1'b1;
      dataiValue = 36'o321; timeoutClr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst pre xfer", 36'(ebusXfer), 36'(1));
      chk("rst pre drv", 36'(drv.driving), 36'(1));
      #1 CROBAR_N = 1'b0;
      exp_to = 1'b0;
      #1;
      quiet("rst async");
      chk("rst timedOut", 36'(timedOut), 36'(exp_to));
      @(posedge clk); #1 CROBAR_N = 1'b1; ebusDemand = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         quiet($sformatf("rst post%0d", c));
      end
      run("after rst", DEV, 3'd0, 36'o0, 36'o42, 36'o0, 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
